regfile_scoreboard: RTL

Parametrised multi-read-port register file for the hazard-stall pipeline. It replaces the single-instance 2-read/1-write, negedge-write file with a posedge-write file that adds:
- a configurable number of read ports;
- same-cycle write-to-read bypass;
- a per-register pending scoreboard that raises the decode-stage stall;
- a hardware clear sequence after reset.

It sits between decode (read/issue) and writeback (write).

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_scoreboard_pending_table.sv | 36 +++
 rtl/regfile_scoreboard.sv | 75 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, defaults and slice helper for the scoreboarded register file
package regfile_pkg;
  typedef enum logic {CLEAR, RUN} state_e;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_RD   = 2;
  localparam int DEF_ZERO_REG = 1;
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction
endpackage

// File: rtl/regfile_scoreboard_pending_table.sv
// regfile_scoreboard_pending_table: per-register outstanding-producer bits with write-clear bypass on lookups
module regfile_scoreboard_pending_table
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     flush_en,
  input  logic [ADDR_W-1:0]        flush_addr,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_addr,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr,
  input  logic [NUM_RD*ADDR_W-1:0] lk_addr,
  output logic [NUM_RD-1:0]        lk_pending
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0] pend_q, pend_d;
  // set follows clear so a new producer issued alongside writeback stays pending
  always_comb begin
    pend_d = pend_q;
    if (flush_en) pend_d[flush_addr] = 1'b0;
    else begin
      if (clr_en) pend_d[clr_addr] = 1'b0;
      if (set_en) pend_d[set_addr] = 1'b1;
    end
  end
  always_ff @(posedge clk) pend_q <= pend_d;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_lk
    logic [ADDR_W-1:0] a;
    assign a = lk_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    assign lk_pending[i] = pend_q[a] & ~(clr_en & (clr_addr == a)) & ~((ZERO_REG != 0) & (a == '0));
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-read-port register file with write bypass, pending scoreboard and post-reset clear
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  input  logic [NUM_RD-1:0]        rd_use,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     busy,
  output logic                     stall
);
  localparam int DEPTH = 1 << ADDR_W;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_ok, issue_ok;
  logic [NUM_RD-1:0] lk_pending;
  assign busy     = (state_q == CLEAR);
  assign wr_ok    = ~busy & wr_en & ((wr_addr != '0) | (ZERO_REG == 0));
  assign issue_ok = ~busy & issue_en & ((issue_addr != '0) | (ZERO_REG == 0));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    if (busy) begin
      mem_d[cnt_q] = '0;
      cnt_d        = cnt_q + 1'b1;
      state_d      = (cnt_q == ADDR_W'(DEPTH - 1)) ? RUN : CLEAR;
    end else if (wr_ok) mem_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  regfile_scoreboard_pending_table #(
    .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(ZERO_REG)
  ) u_pend (
    .clk       (clk),
    .flush_en  (busy),
    .flush_addr(cnt_q),
    .set_en    (issue_ok),
    .set_addr  (issue_addr),
    .clr_en    (wr_ok),
    .clr_addr  (wr_addr),
    .lk_addr   (rd_addr),
    .lk_pending(lk_pending)
  );
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    assign rd_data[slice_lo(i, DATA_W) +: DATA_W] =
      (busy | ((ZERO_REG != 0) & (a == '0))) ? '0 : (wr_ok & (wr_addr == a)) ? wr_data : mem_q[a];
    assign rd_pending[i] = ~busy & lk_pending[i];
  end
  assign stall = busy | |(rd_use & rd_pending);
endmodule
